// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl_pkg
//  Purpose  : Shared encodings for the multiply/divide unit: md_op opcodes,
//             sequencer state encoding and the R-type funct codes the
//             decoder uses to raise start / mf_req / mt_hi / mt_lo.
//  Revision : 1.0  initial release
// ============================================================================
package mdu_ctrl_pkg;

    // md_op encoding presented by the EX stage
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    // R-type funct field values decoded by ctrl
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage : mdu_ctrl_pkg
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : One combinational step of the iterative multiply/divide.
//             Multiply (is_div=0): shift-add. {acc_hi,acc_lo} holds the
//               partial product in acc_hi and the remaining multiplier bits
//               in acc_lo; operand is the multiplicand magnitude.
//             Divide (is_div=1): restoring step. acc_hi is the partial
//               remainder, acc_lo shifts dividend bits out at the top and
//               quotient bits in at the bottom; operand is the divisor.
//  Ports    : is_div          step type select
//             acc_hi/acc_lo   current accumulator halves
//             operand         multiplicand or divisor magnitude
//             nxt_hi/nxt_lo   accumulator after this step
//  Revision : 1.0  initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   w_sum;     // partial product plus carry-out
    logic [WIDTH:0]   w_shift;   // remainder shifted left with next dividend bit
    logic [WIDTH-1:0] w_rem;     // trial remainder
    logic             w_ge;      // trial subtraction does not borrow

    assign w_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    assign w_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, operand});
    // When w_ge holds the true difference is below operand, so it fits WIDTH bits.
    assign w_rem   = w_shift[WIDTH-1:0] - operand;

    always_comb begin
        nxt_hi = acc_hi;
        nxt_lo = acc_lo;
        if (is_div) begin
            nxt_hi = w_ge ? w_rem : w_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], w_ge};
        end else begin
            nxt_hi = w_sum[WIDTH:1];
            nxt_lo = {w_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule : mdu_iter
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl
//  Purpose  : Iterative MIPS multiply/divide sequencer owning HI/LO.
//             mult/multu/div/divu run one bit per cycle (ITER+1 cycles busy)
//             and the pipeline is stalled while a dependent or conflicting
//             instruction sits in EX.
//  Ports    : clk, rst            clock, async active-high reset
//             start, md_op        operation issue and opcode
//             opa, opb            rs / rt operands
//             mf_req, mt_hi,      mfhi/mflo, mthi, mtlo present in EX
//             mt_lo, mt_data
//             hi, lo              architectural HI/LO
//             busy, stall, done   status, pipeline freeze, completion pulse
//  Revision : 1.0  initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32     // must equal WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             mf_req,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CNT_W = $clog2(ITER);

    mdu_state_e         r_state;
    mdu_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_opd;
    logic               r_is_div;
    logic               r_neg_q;     // negate product / quotient
    logic               r_neg_r;     // negate remainder
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_it_hi;
    logic [WIDTH-1:0]   w_it_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign w_is_div = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign w_mag_a  = (w_signed && opa[WIDTH-1]) ? -opa : opa;
    assign w_mag_b  = (w_signed && opb[WIDTH-1]) ? -opb : opb;

    // Sign correction on the magnitude result. The remainder follows the
    // dividend, which also makes divide-by-zero return the original dividend.
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? -w_prod   : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix  = r_neg_r ? -r_acc_hi : r_acc_hi;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div  (r_is_div),
        .acc_hi  (r_acc_hi),
        .acc_lo  (r_acc_lo),
        .operand (r_opd),
        .nxt_hi  (w_it_hi),
        .nxt_lo  (w_it_lo)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MDU_IDLE: if (start)          w_state_nxt = MDU_RUN;
            MDU_RUN:  if (r_cnt == '0)    w_state_nxt = MDU_FIX;
            MDU_FIX:                      w_state_nxt = MDU_IDLE;
            default:                      w_state_nxt = MDU_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, counter and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opd    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MDU_IDLE: begin
                    if (start) begin
                        // start has priority; a coincident mt write is dropped
                        r_cnt    <= CNT_W'(ITER - 1);
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        r_neg_r  <= w_signed && opa[WIDTH-1];
                        r_acc_hi <= '0;
                        // multiply shifts the multiplier through acc_lo,
                        // divide shifts the dividend through it
                        r_acc_lo <= w_is_div ? w_mag_a : w_mag_b;
                        r_opd    <= w_is_div ? w_mag_b : w_mag_a;
                    end else begin
                        if (mt_hi) r_hi <= mt_data;
                        if (mt_lo) r_lo <= mt_data;
                    end
                end
                MDU_RUN: begin
                    r_acc_hi <= w_it_hi;
                    r_acc_lo <= w_it_lo;
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                MDU_FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != MDU_IDLE);
    assign stall = busy & (start | mf_req | mt_hi | mt_lo);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule : mdu_ctrl
`default_nettype wire
